// File: rtl/ext_bus_interface_pkg.sv
// Shared state encoding, pin_io control bit positions and width helper for the external bus unit.
package ext_bus_interface_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_TURN = 3'd4
    } state_t;

    localparam int CTL_RW   = 0;
    localparam int CTL_LAST = 1;

    // Counter width able to index n items; never zero so single-item counters stay legal.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ext_bus_interface_if.sv
// Core request/response handshake plus TT pin group; slave = bus unit side, master = core/pins side.
interface ext_bus_interface_if #(
    parameter int ADDR_W     = 16,
    parameter int PIN_W      = 8,
    parameter int DATA_BEATS = 1
) ();
    localparam int DATA_W = PIN_W * DATA_BEATS;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;
    logic [PIN_W-1:0]  pin_out;
    logic [PIN_W-1:0]  pin_io_out;
    logic [PIN_W-1:0]  pin_io_oe;
    logic [PIN_W-1:0]  pin_io_in;
    logic              ext_rdy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, pin_io_in, ext_rdy,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout, pin_out, pin_io_out, pin_io_oe
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, pin_io_in, ext_rdy,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, pin_out, pin_io_out, pin_io_oe
    );

endinterface

// File: rtl/ext_bus_wait_timer.sv
// Per-beat wait counter: clr restarts it, en counts a wait cycle, saturating at WAIT_MAX.
// expire is combinational: high on the WAIT_MAX-th consecutive wait cycle.
module ext_bus_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == CNT_LAST);

endmodule

// File: rtl/ext_bus_interface.sv
// One-at-a-time bus unit: serialises address in PIN_W chunks, moves data in beats with ext_rdy waits.
// Latency ADDR_PH+DATA_BEATS+1 plus wait cycles; req_ready only in IDLE, response has no backpressure.
module ext_bus_interface
    import ext_bus_interface_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int PIN_W      = 8,
    parameter int DATA_BEATS = 1,
    parameter int WAIT_MAX   = 15
) (
    input logic            clk,
    input logic            rst,
    ext_bus_interface_if.slave bus
);
    localparam int ADDR_PH = (ADDR_W + PIN_W - 1) / PIN_W;
    localparam int ADDR_PW = ADDR_PH * PIN_W;
    localparam int DATA_W  = PIN_W * DATA_BEATS;
    localparam int PH_W    = cnt_w(ADDR_PH);
    localparam int BT_W    = cnt_w(DATA_BEATS);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(ADDR_PH - 1);
    localparam logic [BT_W-1:0] LAST_BT = BT_W'(DATA_BEATS - 1);

    state_t             state, state_n;
    logic               we_r;
    logic [ADDR_PW-1:0] addr_r;
    logic [DATA_W-1:0]  wdata_r;
    logic [DATA_W-1:0]  rdata_r;
    logic               timeout_r;
    logic [PH_W-1:0]    phase;
    logic [BT_W-1:0]    beat;

    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_expire;

    logic               req_ready;
    logic               rsp_valid;
    logic [DATA_W-1:0]  rsp_rdata;
    logic               rsp_timeout;
    logic [PIN_W-1:0]   pin_out;
    logic [PIN_W-1:0]   pin_io_out;
    logic [PIN_W-1:0]   pin_io_oe;

    ext_bus_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_timeout = 1'b0;
        pin_out     = '0;
        pin_io_out  = '0;
        pin_io_oe   = '0;
        tmr_clr     = 1'b1;
        tmr_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_n = ST_ADDR;
                end
            end
            ST_ADDR: begin
                pin_out              = addr_r[phase*PIN_W +: PIN_W];
                pin_io_out[CTL_RW]   = ~we_r;
                pin_io_out[CTL_LAST] = (phase == LAST_PH);
                pin_io_oe            = '1;
                if (phase == LAST_PH) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                pin_out = addr_r[(ADDR_PH-1)*PIN_W +: PIN_W];
                if (we_r) begin
                    pin_io_out = wdata_r[beat*PIN_W +: PIN_W];
                    pin_io_oe  = '1;
                end
                // A completed beat restarts the wait budget for the next one.
                tmr_clr = bus.ext_rdy;
                tmr_en  = ~bus.ext_rdy;
                if (bus.ext_rdy) begin
                    if (beat == LAST_BT) begin
                        state_n = ST_RESP;
                    end
                end else if (tmr_expire) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid   = 1'b1;
                rsp_rdata   = rdata_r;
                rsp_timeout = timeout_r;
                state_n     = we_r ? ST_IDLE : ST_TURN;
            end
            ST_TURN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            rdata_r   <= '0;
            timeout_r <= 1'b0;
            phase     <= '0;
            beat      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_r      <= bus.req_we;
                        addr_r    <= ADDR_PW'(bus.req_addr);
                        wdata_r   <= bus.req_wdata;
                        rdata_r   <= '0;
                        timeout_r <= 1'b0;
                        phase     <= '0;
                        beat      <= '0;
                    end
                end
                ST_ADDR: begin
                    if (phase != LAST_PH) begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bus.ext_rdy) begin
                        if (!we_r) begin
                            rdata_r[beat*PIN_W +: PIN_W] <= bus.pin_io_in;
                        end
                        if (beat != LAST_BT) begin
                            beat <= beat + 1'b1;
                        end
                    end else if (tmr_expire) begin
                        timeout_r <= 1'b1;
                        rdata_r   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_rdata   = rsp_rdata;
    assign bus.rsp_timeout = rsp_timeout;
    assign bus.pin_out     = pin_out;
    assign bus.pin_io_out  = pin_io_out;
    assign bus.pin_io_oe   = pin_io_oe;

endmodule

// File: tb/tb_ext_bus_interface.sv
// Bench for ext_bus_interface: single-beat unit (WAIT_MAX 15) and two-beat unit (WAIT_MAX 3).
module tb_ext_bus_interface;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] rdata;
        logic        tmo;
        int          due;
    } exp_t;
    exp_t sb[$];

    ext_bus_interface_if #(.ADDR_W(16), .PIN_W(8), .DATA_BEATS(1)) bus1 ();
    ext_bus_interface_if #(.ADDR_W(16), .PIN_W(8), .DATA_BEATS(2)) bus2 ();

    ext_bus_interface #(.ADDR_W(16), .PIN_W(8), .DATA_BEATS(1), .WAIT_MAX(15)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    ext_bus_interface #(.ADDR_W(16), .PIN_W(8), .DATA_BEATS(2), .WAIT_MAX(3)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_rsp(input bit sel, input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if ((sel ? bus2.rsp_valid : bus1.rsp_valid) === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus1.req_ready); end
        checks++; if (bus1.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus1.rsp_valid); end
        checks++; if (bus1.rsp_rdata !== 8'h00 || bus1.rsp_timeout !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %h/%b want 00/0", bus1.rsp_rdata, bus1.rsp_timeout); end
        checks++; if ({bus1.pin_out, bus1.pin_io_out, bus1.pin_io_oe} !== 24'h0) begin errors++; $display("FAIL reset_pins: got %h want 000000", {bus1.pin_out, bus1.pin_io_out, bus1.pin_io_oe}); end
        checks++; if (bus2.req_ready !== 1'b1 || bus2.rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_dut2: got %b/%h want 1/0000", bus2.req_ready, bus2.rsp_rdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        int t; bit found; exp_t e;
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 16'h12AB;
        bus1.ext_rdy = 1'b1; bus1.pin_io_in = 8'h5A;
        checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL read_accept_ready: got %b want 1", bus1.req_ready); end
        t = cyc; sb.push_back('{16'h005A, 1'b0, t + 4});
        @(negedge clk);
        bus1.req_valid = 1'b0; bus1.req_addr = 16'hFFFF;
        checks++; if (bus1.pin_out !== 8'hAB || bus1.pin_io_out !== 8'h01 || bus1.pin_io_oe !== 8'hFF) begin errors++; $display("FAIL read_addr_ph0: got %h/%h/%h want AB/01/FF", bus1.pin_out, bus1.pin_io_out, bus1.pin_io_oe); end
        checks++; if (bus1.req_ready !== 1'b0) begin errors++; $display("FAIL read_busy_ready: got %b want 0", bus1.req_ready); end
        @(negedge clk);
        checks++; if (bus1.pin_out !== 8'h12 || bus1.pin_io_out !== 8'h03) begin errors++; $display("FAIL read_addr_ph1: got %h/%h want 12/03", bus1.pin_out, bus1.pin_io_out); end
        @(negedge clk);
        checks++; if (bus1.pin_io_oe !== 8'h00 || bus1.pin_out !== 8'h12) begin errors++; $display("FAIL read_data_pins: got oe %h out %h want 00/12", bus1.pin_io_oe, bus1.pin_out); end
        wait_rsp(1'b0, 4, found);
        checks++; if (!found) begin errors++; $display("FAIL read_rsp_seen: got none want rsp_valid"); sb.delete(); end
        else begin
            e = sb.pop_front();
            checks++; if (cyc !== e.due) begin errors++; $display("FAIL read_latency: got cycle %0d want %0d", cyc, e.due); end
            checks++; if (bus1.rsp_rdata !== e.rdata[7:0] || bus1.rsp_timeout !== e.tmo) begin errors++; $display("FAIL read_rsp_data: got %h/%b want %h/%b", bus1.rsp_rdata, bus1.rsp_timeout, e.rdata[7:0], e.tmo); end
        end
        @(negedge clk);
        checks++; if (bus1.rsp_valid !== 1'b0 || bus1.rsp_rdata !== 8'h00 || bus1.pin_io_oe !== 8'h00 || bus1.req_ready !== 1'b0) begin errors++; $display("FAIL read_turn: got v%b d%h oe%h rdy%b want 0/00/00/0", bus1.rsp_valid, bus1.rsp_rdata, bus1.pin_io_oe, bus1.req_ready); end
        @(negedge clk);
        checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL read_idle_again: got %b want 1", bus1.req_ready); end
    endtask

    task automatic test_write_wait();
        int t; bit found; exp_t e;
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 16'h0010;
        bus1.req_wdata = 8'hC3; bus1.ext_rdy = 1'b0;
        t = cyc; sb.push_back('{16'h0000, 1'b0, t + 7});
        @(negedge clk);
        bus1.req_valid = 1'b0; bus1.req_wdata = 8'h00;
        checks++; if (bus1.pin_out !== 8'h10 || bus1.pin_io_out !== 8'h00) begin errors++; $display("FAIL write_addr_ph0: got %h/%h want 10/00", bus1.pin_out, bus1.pin_io_out); end
        @(negedge clk);
        checks++; if (bus1.pin_out !== 8'h00 || bus1.pin_io_out !== 8'h02) begin errors++; $display("FAIL write_addr_ph1: got %h/%h want 00/02", bus1.pin_out, bus1.pin_io_out); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus1.pin_io_oe !== 8'hFF || bus1.pin_io_out !== 8'hC3 || bus1.rsp_valid !== 1'b0) begin errors++; $display("FAIL write_data_cyc%0d: got oe %h out %h v %b want FF/C3/0", i, bus1.pin_io_oe, bus1.pin_io_out, bus1.rsp_valid); end
            if (i == 3) bus1.ext_rdy = 1'b1;
        end
        wait_rsp(1'b0, 3, found);
        checks++; if (!found) begin errors++; $display("FAIL write_rsp_seen: got none want rsp_valid"); sb.delete(); end
        else begin
            e = sb.pop_front();
            checks++; if (cyc !== e.due) begin errors++; $display("FAIL write_latency: got cycle %0d want %0d", cyc, e.due); end
            checks++; if (bus1.rsp_rdata !== e.rdata[7:0] || bus1.rsp_timeout !== e.tmo) begin errors++; $display("FAIL write_rsp_data: got %h/%b want %h/%b", bus1.rsp_rdata, bus1.rsp_timeout, e.rdata[7:0], e.tmo); end
        end
        @(negedge clk);
        checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL write_idle_next: got %b want 1", bus1.req_ready); end
    endtask

    task automatic test_timeout();
        int t; bit found; exp_t e;
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 16'h0BEE;
        bus1.ext_rdy = 1'b0; bus1.pin_io_in = 8'h77;
        t = cyc; sb.push_back('{16'h0000, 1'b1, t + 2 + 15 + 1});
        @(negedge clk);
        bus1.req_valid = 1'b0;
        wait_rsp(1'b0, 30, found);
        checks++; if (!found) begin errors++; $display("FAIL timeout_rsp_seen: got none want rsp_valid"); sb.delete(); end
        else begin
            e = sb.pop_front();
            checks++; if (cyc !== e.due) begin errors++; $display("FAIL timeout_latency: got cycle %0d want %0d", cyc, e.due); end
            checks++; if (bus1.rsp_rdata !== e.rdata[7:0] || bus1.rsp_timeout !== e.tmo) begin errors++; $display("FAIL timeout_rsp: got %h/%b want %h/%b", bus1.rsp_rdata, bus1.rsp_timeout, e.rdata[7:0], e.tmo); end
        end
        @(negedge clk);
        checks++; if (bus1.rsp_timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b want 0", bus1.rsp_timeout); end
        @(negedge clk);
        bus1.ext_rdy = 1'b1;
    endtask

    task automatic test_two_beat();
        int t; bit found; exp_t e;
        // Two waits per beat: below WAIT_MAX=3 only if the counter restarts each beat.
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_addr = 16'h4321;
        bus2.ext_rdy = 1'b0; bus2.pin_io_in = 8'h34;
        t = cyc; sb.push_back('{16'h1234, 1'b0, t + 9});
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) bus2.req_valid = 1'b0;
            bus2.ext_rdy   = (i == 5 || i == 8);
            bus2.pin_io_in = (i <= 5) ? 8'h34 : 8'h12;
            if (i == 6) begin
                checks++; if (bus2.pin_io_oe !== 8'h00 || bus2.pin_out !== 8'h43) begin errors++; $display("FAIL twobeat_pins: got oe %h out %h want 00/43", bus2.pin_io_oe, bus2.pin_out); end
            end
        end
        wait_rsp(1'b1, 3, found);
        checks++; if (!found) begin errors++; $display("FAIL twobeat_rsp_seen: got none want rsp_valid"); sb.delete(); end
        else begin
            e = sb.pop_front();
            checks++; if (cyc !== e.due) begin errors++; $display("FAIL twobeat_latency: got cycle %0d want %0d", cyc, e.due); end
            checks++; if (bus2.rsp_rdata !== e.rdata || bus2.rsp_timeout !== e.tmo) begin errors++; $display("FAIL twobeat_rsp: got %h/%b want %h/%b", bus2.rsp_rdata, bus2.rsp_timeout, e.rdata, e.tmo); end
        end
        repeat (2) @(negedge clk);
        // Three consecutive waits on the first beat hit WAIT_MAX=3.
        bus2.req_valid = 1'b1; bus2.ext_rdy = 1'b0; bus2.pin_io_in = 8'hEE;
        t = cyc; sb.push_back('{16'h0000, 1'b1, t + 2 + 3 + 1});
        @(negedge clk);
        bus2.req_valid = 1'b0;
        wait_rsp(1'b1, 10, found);
        checks++; if (!found) begin errors++; $display("FAIL twobeat_tmo_seen: got none want rsp_valid"); sb.delete(); end
        else begin
            e = sb.pop_front();
            checks++; if (cyc !== e.due) begin errors++; $display("FAIL twobeat_tmo_latency: got cycle %0d want %0d", cyc, e.due); end
            checks++; if (bus2.rsp_rdata !== e.rdata || bus2.rsp_timeout !== e.tmo) begin errors++; $display("FAIL twobeat_tmo_rsp: got %h/%b want %h/%b", bus2.rsp_rdata, bus2.rsp_timeout, e.rdata, e.tmo); end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int t; bit found; bit seen; exp_t e;
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 16'h5555; bus1.ext_rdy = 1'b0;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus1.req_ready !== 1'b1 || bus1.rsp_valid !== 1'b0 || bus1.rsp_rdata !== 8'h00) begin errors++; $display("FAIL midrst_handshake: got rdy %b v %b d %h want 1/0/00", bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata); end
        checks++; if ({bus1.pin_out, bus1.pin_io_out, bus1.pin_io_oe} !== 24'h0) begin errors++; $display("FAIL midrst_pins: got %h want 000000", {bus1.pin_out, bus1.pin_io_out, bus1.pin_io_oe}); end
        @(negedge clk);
        rst = 1'b0; bus1.ext_rdy = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus1.rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midrst_no_rsp: got rsp_valid want none"); end
        bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 16'h00A5; bus1.req_wdata = 8'h3C;
        t = cyc; sb.push_back('{16'h0000, 1'b0, t + 4});
        @(negedge clk);
        bus1.req_valid = 1'b0;
        wait_rsp(1'b0, 6, found);
        checks++; if (!found) begin errors++; $display("FAIL midrst_fresh_seen: got none want rsp_valid"); sb.delete(); end
        else begin
            e = sb.pop_front();
            checks++; if (cyc !== e.due || bus1.rsp_timeout !== e.tmo) begin errors++; $display("FAIL midrst_fresh_rsp: got cycle %0d tmo %b want %0d/%b", cyc, bus1.rsp_timeout, e.due, e.tmo); end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic        ops_we   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] ops_addr [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        int k = 0; int nresp = 0; int next_ready; bit adv = 1'b0; bit exp_rdy; exp_t e;
        @(negedge clk);
        bus1.ext_rdy = 1'b1; bus1.pin_io_in = 8'h66;
        bus1.req_valid = 1'b1; bus1.req_we = ops_we[0]; bus1.req_addr = ops_addr[0]; bus1.req_wdata = 8'h99;
        next_ready = cyc;
        for (int c = 0; c < 40 && nresp < 4; c++) begin
            exp_rdy = (cyc >= next_ready);
            checks++; if (bus1.req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready_c%0d: got %b want %b", cyc, bus1.req_ready, exp_rdy); end
            if (bus1.rsp_valid === 1'b1) begin
                nresp++;
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_unexpected_rsp: got rsp at %0d want none", cyc);
                end else begin
                    e = sb.pop_front();
                    checks++; if (cyc !== e.due || bus1.rsp_rdata !== e.rdata[7:0]) begin errors++; $display("FAIL b2b_rsp: got cycle %0d data %h want %0d/%h", cyc, bus1.rsp_rdata, e.due, e.rdata[7:0]); end
                end
            end
            if (bus1.req_ready === 1'b1 && bus1.req_valid === 1'b1) begin
                sb.push_back('{bus1.req_we ? 16'h0000 : 16'h0066, 1'b0, cyc + 4});
                next_ready = cyc + 4 + (bus1.req_we ? 1 : 2);
                adv = 1'b1;
            end
            @(negedge clk);
            if (adv) begin
                adv = 1'b0; k++;
                if (k < 4) begin bus1.req_we = ops_we[k]; bus1.req_addr = ops_addr[k]; end
                else bus1.req_valid = 1'b0;
            end
        end
        checks++; if (nresp != 4 || sb.size() != 0) begin errors++; $display("FAIL b2b_count: got %0d responses, %0d pending want 4/0", nresp, sb.size()); end
    endtask

    initial begin
        rst = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus1.pin_io_in = '0; bus1.ext_rdy = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus2.pin_io_in = '0; bus2.ext_rdy = 1'b0;
        test_reset();
        test_read();
        test_write_wait();
        test_timeout();
        test_two_beat();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
